// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the MEM stage of the pipelined MIPS core.
//   Accepts one load or store at a time and services it after a fixed latency.
//   While the access is in flight it holds the pipeline with stall. When the
//   access finishes it pulses ready for one cycle. A malformed request (both
//   strobes high, or an address that is not word aligned) is rejected with a
//   one-cycle err pulse.
//
// Parameters
//   DEPTH_LOG2 : log2 of the memory depth in 32-bit words
//   LATENCY    : wait cycles per access, legal range 1..15
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   MemRead  in   load request
//   MemWrite in   store request
//   addr     in   [31:0] byte address; upper bits beyond the array wrap
//   wdata    in   [31:0] store data
//   rdata    out  [31:0] registered load data, held until the next load
//   ready    out  one-cycle pulse: access complete
//   stall    out  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
//   err      out  one-cycle pulse: rejected request
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    stall_c;
  logic                    mem_we;

  logic [31:0]             mem [DEPTH];

  logic req_any, req_valid, req_bad;

  // Upper address bits deliberately take no part in indexing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:DEPTH_LOG2+2];

  assign req_any   = MemRead | MemWrite;
  assign req_valid = (MemRead ^ MemWrite) && (addr[1:0] == 2'b00);
  assign req_bad   = req_any && !req_valid;

  // The store lands on the same edge that leaves WAIT.
  assign mem_we = (state_q == S_WAIT) && (cnt_q == 4'd0) && wr_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    stall_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // While err is still showing, acceptance waits one cycle. That keeps
        // err and stall from ever being high together.
        if (req_valid && !err_q) begin
          stall_c = 1'b1;
          wr_d    = MemWrite;
          idx_d   = addr[DEPTH_LOG2+1:2];
          wdata_d = wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = S_WAIT;
        end else if (req_bad) begin
          err_d = 1'b1;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!wr_q) rdata_d = mem[idx_q];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // The same instruction is still presented here. Its inputs are ignored.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the pre-edge value regardless of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array has no reset. Clearing it would block RAM inference, and
  // its contents are undefined after power-up anyway.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  assign rdata = rdata_q;
  assign ready = (state_q == S_DONE);
  // Gated so that a request held during reset cannot raise stall.
  assign stall = stall_c & rst_n;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder. Unit 0 uses LATENCY=2 and unit 1 uses
//   LATENCY=1. Both share the clock and reset, and each has its own request
//   inputs.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mem_read, mem_write;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [1:0]  ready, stall, err;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
    .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .ready(ready[0]), .stall(stall[0]), .err(err[0])
  );

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
    .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .ready(ready[1]), .stall(stall[1]), .err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // A complete access on unit u. Inputs are held until ready is seen. Stall
  // is counted, and the cycle of the ready pulse is recorded. The task
  // returns in the IDLE cycle that follows DONE.
  task automatic access(input int u, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int lat, input string tag,
                        input logic churn, input logic [31:0] ca,
                        input logic [31:0] cd);
    int stall_cnt;
    int ready_cyc;
    stall_cnt    = 0;
    ready_cyc    = -1;
    mem_read[u]  = !wr;
    mem_write[u] = wr;
    addr[u]      = a;
    wdata[u]     = d;
    for (int c = 0; c < 40 && ready_cyc < 0; c++) begin
      @(negedge clk);
      if (stall[u]) stall_cnt++;
      if (ready[u]) ready_cyc = c;
      if (ready[u] && stall[u]) check({tag, "_ready_stall_excl"}, 32'(ready[u] & stall[u]), 32'd0);
      @(posedge clk); #1;
      if (churn && c == 0) begin
        addr[u]  = ca;
        wdata[u] = cd;
      end
    end
    mem_read[u]  = 1'b0;
    mem_write[u] = 1'b0;
    check({tag, "_completed"}, 32'(ready_cyc >= 0), 32'd1);
    check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(lat + 1));
    check({tag, "_ready_cycle"}, 32'(ready_cyc), 32'(lat + 1));
  endtask

  // A rejected request held for one cycle on unit 0.
  task automatic bad_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] rdata_before, input string tag);
    mem_read[0]  = rd;
    mem_write[0] = wr;
    addr[0]      = a;
    @(negedge clk);
    check({tag, "_stall_c0"}, 32'(stall[0]), 32'd0);
    check({tag, "_err_c0"}, 32'(err[0]), 32'd0);
    @(posedge clk); #1;
    mem_read[0]  = 1'b0;
    mem_write[0] = 1'b0;
    @(negedge clk);
    check({tag, "_err_c1"}, 32'(err[0]), 32'd1);
    check({tag, "_stall_c1"}, 32'(stall[0]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_err_c2"}, 32'(err[0]), 32'd0);
    check({tag, "_rdata_kept"}, rdata[0], rdata_before);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_read  = 2'b00;
    mem_write = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i]  = 32'd0;
      wdata[i] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata[0], 32'd0);
    check("rst_ready", 32'(ready[0]), 32'd0);
    check("rst_stall", 32'(stall[0]), 32'd0);
    check("rst_err", 32'(err[0]), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Store, then load the same word.
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 2, "st10", 1'b0, 0, 0);
    access(0, 1'b0, 32'h10, 32'h0, 2, "ld10", 1'b0, 0, 0);
    check("ld10_rdata", rdata[0], 32'hDEADBEEF);

    // Address 0x400 wraps to word 0.
    access(0, 1'b1, 32'h400, 32'h12345678, 2, "st400", 1'b0, 0, 0);
    check("st_keeps_rdata", rdata[0], 32'hDEADBEEF);
    access(0, 1'b0, 32'h000, 32'h0, 2, "ld000", 1'b0, 0, 0);
    check("wrap_rdata", rdata[0], 32'h12345678);

    // A misaligned load is rejected.
    bad_req(1'b1, 1'b0, 32'h13, 32'h12345678, "misal");

    // Conflicting strobes leave word 0x20 untouched.
    access(0, 1'b1, 32'h20, 32'h11112222, 2, "st20", 1'b0, 0, 0);
    bad_req(1'b1, 1'b1, 32'h20, 32'h12345678, "both");
    access(0, 1'b0, 32'h20, 32'h0, 2, "ld20", 1'b0, 0, 0);
    check("both_word_kept", rdata[0], 32'h11112222);

    // Inputs change while the store is in flight.
    access(0, 1'b1, 32'h40, 32'h5555AAAA, 2, "st40", 1'b0, 0, 0);
    access(0, 1'b1, 32'h10, 32'hCAFEF00D, 2, "churn", 1'b1, 32'h40, 32'h0);
    access(0, 1'b0, 32'h10, 32'h0, 2, "ld10b", 1'b0, 0, 0);
    check("churn_store_done", rdata[0], 32'hCAFEF00D);
    access(0, 1'b0, 32'h40, 32'h0, 2, "ld40", 1'b0, 0, 0);
    check("churn_40_kept", rdata[0], 32'h5555AAAA);

    // Reset arrives in the first WAIT cycle of a store.
    access(0, 1'b1, 32'h30, 32'h01020304, 2, "st30", 1'b0, 0, 0);
    mem_write[0] = 1'b1;
    addr[0]      = 32'h30;
    wdata[0]     = 32'hAAAA5555;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_stall", 32'(stall[0]), 32'd0);
    check("rstmid_ready", 32'(ready[0]), 32'd0);
    check("rstmid_err", 32'(err[0]), 32'd0);
    check("rstmid_rdata", rdata[0], 32'd0);
    mem_write[0] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    access(0, 1'b0, 32'h30, 32'h0, 2, "ld30", 1'b0, 0, 0);
    check("rstmid_no_store", rdata[0], 32'h01020304);

    // LATENCY=1 unit: two back-to-back loads.
    access(1, 1'b1, 32'h0, 32'hA0A0A0A0, 1, "u1_st0", 1'b0, 0, 0);
    access(1, 1'b1, 32'h4, 32'hB1B1B1B1, 1, "u1_st4", 1'b0, 0, 0);
    access(1, 1'b0, 32'h0, 32'h0, 1, "u1_ld0", 1'b0, 0, 0);
    check("u1_ld0_rdata", rdata[1], 32'hA0A0A0A0);
    access(1, 1'b0, 32'h4, 32'h0, 1, "u1_ld4", 1'b0, 0, 0);
    check("u1_ld4_rdata", rdata[1], 32'hB1B1B1B1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
